sdram_wb_bridge: RTL and testbench
==================================

Name: sdram_wb_bridge

Overview:
- Upstream front-end for the 16-bit SDRAM controller; all logic in the sdram_clk domain.
- Converts 32-bit Wishbone classic slave cycles into the controller's halfword acc/ack interface.
- Reads fill a one-line read buffer from the controller's burst. Later reads that hit the line are served without an SDRAM access.
- Writes are split into two halfword writes and written through; a write that hits the buffered line also updates the line.

Parameters:
BURST_LENGTH, 8, controller burst length in halfwords (2, 4 or 8); line = 2*BURST_LENGTH bytes
LINE_AW, log2(2*BURST_LENGTH), derived localparam, byte-offset width inside a line

Ports:
sdram_clk  in  1  clock
sdram_rst  in  1  synchronous active-high reset
wb_adr_i  in  32  byte address; bits [1:0] ignored
wb_dat_i  in  32  write data, big-endian
wb_sel_i  in  4  byte selects; sel[3] = byte offset 0
wb_we_i  in  1  write enable
wb_cyc_i  in  1  cycle
wb_stb_i  in  1  strobe
wb_dat_o  out  32  read data
wb_ack_o  out  1  acknowledge
ctrl_adr_o  out  32  halfword byte address to controller
ctrl_dat_o  out  16  halfword write data
ctrl_sel_o  out  2  halfword byte selects; [1] = upper byte
ctrl_we_o  out  1  write enable
ctrl_acc_o  out  1  access request
ctrl_ack_i  in  1  controller ack
ctrl_dat_i  in  16  read halfword
ctrl_adr_i  in  32  address of ctrl_dat_i (increments mod burst)

Behaviour:
- Interface: one clock, sdram_clk; reset sdram_rst is synchronous and active-high.
- Reset values: wb_ack_o=0, wb_dat_o=0, ctrl_acc_o=0, ctrl_we_o=0, ctrl_sel_o=0, ctrl_dat_o=0, ctrl_adr_o=0, buffer valid=0, state=IDLE.
- A reset asserted mid-operation aborts it at once; no ack is issued afterwards.
- Request: req = wb_cyc_i & wb_stb_i & ~wb_ack_o. Tag = wb_adr_i[31:LINE_AW]. hit = valid & (tag == buf_tag).
- ctrl_acc_o = acc_r & ~ctrl_ack_i (combinational gate). This prevents a duplicate command in the cycle the controller acks.
- ctrl_adr_o, ctrl_dat_o, ctrl_sel_o and ctrl_we_o are registered. They stay stable from acc_r rising until ctrl_ack_i, because the controller samples dat/sel late after ACTIVATE.
- States:
  - IDLE:
    - req & ~we & hit -> HIT: wb_dat_o = buffer word, wb_ack_o=1 next cycle (latency 1).
    - req & ~we & ~hit -> RD_REQ: ctrl_adr_o = {wb_adr_i[31:2], 2'b00}, acc_r=1.
    - req & we -> WR_HI, or WR_LO if sel[3:2]==0.
    - req & we & sel==0 -> ACK directly; no SDRAM access.
  - RD_REQ: on ctrl_ack_i, acc_r=0, capture ctrl_dat_i at index ctrl_adr_i[LINE_AW-1:1], fill count=1, -> RD_FILL. Valid is cleared on entry to RD_REQ.
  - RD_FILL: capture one halfword per cycle, indexed by ctrl_adr_i. When count reaches BURST_LENGTH: valid=1, buf_tag=tag, -> ACK.
  - WR_HI: ctrl_adr_o = {adr[31:2],2'b00}, dat = wb_dat_i[31:16], sel = wb_sel_i[3:2], we=1. On ack -> WR_LO, or ACK if sel[1:0]==0.
  - WR_LO: ctrl_adr_o = {adr[31:2],2'b10}, dat = wb_dat_i[15:0], sel = wb_sel_i[1:0]. On ack -> ACK.
  - Write-through: on each write ack with hit, merge the selected bytes into the buffer halfword.
  - ACK: wb_ack_o=1 for exactly one cycle; for reads wb_dat_o = buffer word at adr[LINE_AW-1:2]. -> IDLE.
- wb_cyc_i dropped mid-access: the SDRAM transaction completes (a read fill is still stored), wb_ack_o is suppressed, then -> IDLE.
- Halfword order within a word is big-endian: offset 0 = bits [31:16].

Decomposition:
- Package sdram_bridge_pkg: state encodings, LINE_AW and buffer-index width helpers.
- Sub-module sdram_line_buf: BURST_LENGTH x 16 storage. Provides a fill write port, a byte-masked write-through port, and a 32-bit word read port.

Test Plan:
- Read miss at 0x00000104 (BL=8): controller acks, then streams halfwords for 0x104..0x10E, wrapping through 0x100..0x102 -> single wb_ack_o after the 8th halfword, wb_dat_o = halfwords {0x104,0x106}; ctrl_acc_o high only until ack.
- Read at 0x00000108 immediately after -> ack 1 cycle after stb, no ctrl_acc_o, data = halfwords {0x108,0x10A}.
- Write 0xAABBCCDD, sel=4'b1111, to 0x108 -> two ctrl writes: (0x108, 0xAABB, 2'b11) then (0x10A, 0xCCDD, 2'b11); one wb_ack_o; a re-read returns 0xAABBCCDD with no SDRAM access.
- Write sel=4'b0011 to 0x200 -> exactly one ctrl write (0x202, dat[15:0], 2'b11); sel=4'b0000 -> ack with no ctrl access.
- wb_cyc_i dropped 2 cycles into RD_FILL -> fill completes, no wb_ack_o, buffer valid; next read of the same line hits.
- sdram_rst asserted during WR_LO -> all outputs at reset values next cycle, valid=0, no ack.

Source files
------------

// File: rtl/sdram_bridge_pkg.sv
// rtl/sdram_bridge_pkg.sv - shared state encoding and line geometry helpers for the SDRAM Wishbone bridge
package sdram_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_FILL,
    ST_WR_HI,
    ST_WR_LO,
    ST_ACK
  } state_t;

  function automatic int line_aw(input int burst_length);
    return $clog2(2 * burst_length);
  endfunction

  function automatic int idx_w(input int burst_length);
    return $clog2(burst_length);
  endfunction

endpackage

// File: rtl/sdram_line_buf.sv
// rtl/sdram_line_buf.sv - one-line halfword buffer with burst fill, byte-masked write-through and 32-bit word read
module sdram_line_buf
  import sdram_bridge_pkg::*;
#(
  parameter int BURST_LENGTH = 8,
  localparam int IW = idx_w(BURST_LENGTH)
) (
  input  logic          clk,
  input  logic          fill_en,
  input  logic [IW-1:0] fill_idx,
  input  logic [15:0]   fill_dat,
  input  logic          wt_en,
  input  logic [IW-1:0] wt_idx,
  input  logic [1:0]    wt_sel,
  input  logic [15:0]   wt_dat,
  input  logic [IW-1:0] rd_idx,
  output logic [31:0]   rd_word
);

  logic [15:0] mem [BURST_LENGTH];

  always_ff @(posedge clk) begin
    if (fill_en) begin
      mem[fill_idx] <= fill_dat;
    end
    if (wt_en) begin
      if (wt_sel[1]) mem[wt_idx][15:8] <= wt_dat[15:8];
      if (wt_sel[0]) mem[wt_idx][7:0]  <= wt_dat[7:0];
    end
  end

  // rd_idx is always even; the odd partner holds the low halfword of the word
  assign rd_word = {mem[rd_idx], mem[rd_idx | IW'(1)]};

endmodule

// File: rtl/sdram_wb_bridge.sv
// rtl/sdram_wb_bridge.sv - Wishbone classic 32-bit slave to 16-bit SDRAM controller bridge with one-line read buffer
module sdram_wb_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int BURST_LENGTH = 8
) (
  input  logic        sdram_clk,
  input  logic        sdram_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [31:0] ctrl_adr_o,
  output logic [15:0] ctrl_dat_o,
  output logic [1:0]  ctrl_sel_o,
  output logic        ctrl_we_o,
  output logic        ctrl_acc_o,
  input  logic        ctrl_ack_i,
  input  logic [15:0] ctrl_dat_i,
  input  logic [31:0] ctrl_adr_i
);

  localparam int LINE_AW = line_aw(BURST_LENGTH);
  localparam int IW      = idx_w(BURST_LENGTH);
  localparam int TW      = 32 - LINE_AW;

  state_t        state;
  logic          acc_r, valid, aborted, cur_we;
  logic [TW-1:0] buf_tag;
  logic [31:0]   cur_adr, adr_sel, rd_word;
  logic [15:0]   lo_dat;
  logic [1:0]    lo_sel;
  logic [IW:0]   fill_cnt;
  logic [IW-1:0] rd_idx;
  logic          req, hit_now, hit_cur, fill_en, wt_en;
  logic          unused_bits;

  assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign hit_now    = valid && (wb_adr_i[31:LINE_AW] == buf_tag);
  assign hit_cur    = valid && (cur_adr[31:LINE_AW] == buf_tag);
  assign ctrl_acc_o = acc_r & ~ctrl_ack_i;

  // IDLE serves hits straight from the bus address; later states use the latched one
  assign adr_sel = (state == ST_IDLE) ? wb_adr_i : cur_adr;
  assign rd_idx  = adr_sel[LINE_AW-1:1] & ~IW'(1);
  assign fill_en = (state == ST_RD_REQ && ctrl_ack_i) || (state == ST_RD_FILL);
  assign wt_en   = ctrl_ack_i && hit_cur && (state == ST_WR_HI || state == ST_WR_LO);

  assign unused_bits = ^{wb_adr_i[1:0], cur_adr[0], ctrl_adr_i[31:LINE_AW], ctrl_adr_i[0]};

  sdram_line_buf #(
    .BURST_LENGTH(BURST_LENGTH)
  ) u_line_buf (
    .clk      (sdram_clk),
    .fill_en  (fill_en),
    .fill_idx (ctrl_adr_i[LINE_AW-1:1]),
    .fill_dat (ctrl_dat_i),
    .wt_en    (wt_en),
    .wt_idx   (ctrl_adr_o[LINE_AW-1:1]),
    .wt_sel   (ctrl_sel_o),
    .wt_dat   (ctrl_dat_o),
    .rd_idx   (rd_idx),
    .rd_word  (rd_word)
  );

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state      <= ST_IDLE;
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= '0;
      ctrl_adr_o <= '0;
      ctrl_dat_o <= '0;
      ctrl_sel_o <= '0;
      ctrl_we_o  <= 1'b0;
      acc_r      <= 1'b0;
      valid      <= 1'b0;
      aborted    <= 1'b0;
      cur_we     <= 1'b0;
      cur_adr    <= '0;
      buf_tag    <= '0;
      lo_dat     <= '0;
      lo_sel     <= '0;
      fill_cnt   <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      // The SDRAM side always finishes; a dropped cycle only suppresses the final ack
      if (state != ST_IDLE && !wb_cyc_i) aborted <= 1'b1;
      case (state)
        ST_IDLE: begin
          aborted <= 1'b0;
          if (req) begin
            cur_adr <= wb_adr_i;
            cur_we  <= wb_we_i;
            lo_dat  <= wb_dat_i[15:0];
            lo_sel  <= wb_sel_i[1:0];
            if (!wb_we_i) begin
              if (hit_now) begin
                wb_ack_o <= 1'b1;
                wb_dat_o <= rd_word;
              end else begin
                valid      <= 1'b0;
                acc_r      <= 1'b1;
                ctrl_we_o  <= 1'b0;
                ctrl_sel_o <= 2'b11;
                ctrl_adr_o <= {wb_adr_i[31:2], 2'b00};
                state      <= ST_RD_REQ;
              end
            end else if (wb_sel_i == 4'b0000) begin
              state <= ST_ACK;
            end else if (wb_sel_i[3:2] != 2'b00) begin
              acc_r      <= 1'b1;
              ctrl_we_o  <= 1'b1;
              ctrl_adr_o <= {wb_adr_i[31:2], 2'b00};
              ctrl_dat_o <= wb_dat_i[31:16];
              ctrl_sel_o <= wb_sel_i[3:2];
              state      <= ST_WR_HI;
            end else begin
              acc_r      <= 1'b1;
              ctrl_we_o  <= 1'b1;
              ctrl_adr_o <= {wb_adr_i[31:2], 2'b10};
              ctrl_dat_o <= wb_dat_i[15:0];
              ctrl_sel_o <= wb_sel_i[1:0];
              state      <= ST_WR_LO;
            end
          end
        end
        ST_RD_REQ: begin
          if (ctrl_ack_i) begin
            acc_r    <= 1'b0;
            fill_cnt <= (IW+1)'(1);
            state    <= ST_RD_FILL;
          end
        end
        ST_RD_FILL: begin
          fill_cnt <= fill_cnt + (IW+1)'(1);
          if (fill_cnt == (IW+1)'(BURST_LENGTH - 1)) begin
            valid   <= 1'b1;
            buf_tag <= cur_adr[31:LINE_AW];
            state   <= ST_ACK;
          end
        end
        ST_WR_HI: begin
          if (ctrl_ack_i) begin
            if (lo_sel != 2'b00) begin
              ctrl_adr_o <= {cur_adr[31:2], 2'b10};
              ctrl_dat_o <= lo_dat;
              ctrl_sel_o <= lo_sel;
              state      <= ST_WR_LO;
            end else begin
              acc_r     <= 1'b0;
              ctrl_we_o <= 1'b0;
              state     <= ST_ACK;
            end
          end
        end
        ST_WR_LO: begin
          if (ctrl_ack_i) begin
            acc_r     <= 1'b0;
            ctrl_we_o <= 1'b0;
            state     <= ST_ACK;
          end
        end
        ST_ACK: begin
          wb_ack_o <= wb_cyc_i & ~aborted;
          if (!cur_we) wb_dat_o <= rd_word;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// tb/tb_sdram_wb_bridge.sv - directed self-checking bench for sdram_wb_bridge with a simple burst controller model
module tb_sdram_wb_bridge;

  logic        sdram_clk = 1'b0;
  logic        sdram_rst;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o;
  logic [31:0] ctrl_adr_o, ctrl_adr_i;
  logic [15:0] ctrl_dat_o, ctrl_dat_i;
  logic [1:0]  ctrl_sel_o;
  logic        ctrl_we_o, ctrl_acc_o, ctrl_ack_i;

  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;
  int ack_cnt = 0;

  sdram_wb_bridge #(.BURST_LENGTH(8)) dut (
    .sdram_clk  (sdram_clk),
    .sdram_rst  (sdram_rst),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_sel_i   (wb_sel_i),
    .wb_we_i    (wb_we_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .ctrl_adr_o (ctrl_adr_o),
    .ctrl_dat_o (ctrl_dat_o),
    .ctrl_sel_o (ctrl_sel_o),
    .ctrl_we_o  (ctrl_we_o),
    .ctrl_acc_o (ctrl_acc_o),
    .ctrl_ack_i (ctrl_ack_i),
    .ctrl_dat_i (ctrl_dat_i),
    .ctrl_adr_i (ctrl_adr_i)
  );

  always #5 sdram_clk = ~sdram_clk;

  always @(negedge sdram_clk) begin
    if (ctrl_acc_o) acc_cnt++;
    if (wb_ack_o) ack_cnt++;
  end

  function automatic logic [15:0] hw(input logic [31:0] a);
    return a[15:0] + 16'h1000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_start(input logic [31:0] adr, input logic we, input logic [3:0] sel, input logic [31:0] dat);
    @(posedge sdram_clk); #1;
    wb_adr_i = adr; wb_we_i = we; wb_sel_i = sel; wb_dat_i = dat;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
  endtask

  task automatic wb_end();
    @(posedge sdram_clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_wait_ack(output int lat, output logic [31:0] dat);
    lat = -1;
    dat = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge sdram_clk);
      if (wb_ack_o) begin
        lat = i;
        dat = wb_dat_o;
        break;
      end
    end
  endtask

  task automatic ctrl_wait_acc(output logic found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sdram_clk);
      if (ctrl_acc_o) begin
        found = 1'b1;
        break;
      end
    end
    check("acc_seen", 32'(found), 32'd1);
  endtask

  task automatic serve_write(output logic [31:0] a, output logic [15:0] d, output logic [1:0] s, output logic w);
    logic found;
    ctrl_wait_acc(found);
    a = ctrl_adr_o; d = ctrl_dat_o; s = ctrl_sel_o; w = ctrl_we_o;
    @(posedge sdram_clk); #1;
    ctrl_ack_i = found;
    @(posedge sdram_clk); #1;
    ctrl_ack_i = 1'b0;
  endtask

  // Streams a full 8-halfword burst starting at the requested halfword, wrapping within the line
  task automatic serve_read(input logic [31:0] start, input int drop_at, output logic [31:0] a, output logic w);
    logic found;
    ctrl_wait_acc(found);
    a = ctrl_adr_o; w = ctrl_we_o;
    for (int k = 0; k < 8; k++) begin
      @(posedge sdram_clk); #1;
      ctrl_ack_i = (k == 0) && found;
      ctrl_adr_i = {start[31:4], start[3:0] + 4'(2 * k)};
      ctrl_dat_i = hw(ctrl_adr_i);
      if (k == drop_at) begin
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
      end
    end
    @(posedge sdram_clk); #1;
    ctrl_ack_i = 1'b0;
  endtask

  initial begin
    logic [31:0] ca, rd;
    logic [15:0] cd;
    logic [1:0]  cs;
    logic        cw;
    int          lat, a0, k0;

    sdram_rst = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    ctrl_ack_i = 1'b0; ctrl_dat_i = '0; ctrl_adr_i = '0;
    repeat (3) @(posedge sdram_clk);
    #1 sdram_rst = 1'b0;
    @(negedge sdram_clk);
    check("rst_wb_ack", 32'(wb_ack_o), 32'd0);
    check("rst_wb_dat", wb_dat_o, 32'd0);
    check("rst_acc", 32'(ctrl_acc_o), 32'd0);
    check("rst_we", 32'(ctrl_we_o), 32'd0);
    check("rst_ctrl_adr", ctrl_adr_o, 32'd0);

    // read miss, critical halfword first
    a0 = acc_cnt; k0 = ack_cnt;
    wb_start(32'h0000_0104, 1'b0, 4'hF, 32'h0);
    serve_read(32'h0000_0104, -1, ca, cw);
    check("miss_ctrl_adr", ca, 32'h0000_0104);
    check("miss_ctrl_we", 32'(cw), 32'd0);
    wb_wait_ack(lat, rd);
    check("miss_acked", 32'(lat > 0), 32'd1);
    check("miss_data", rd, 32'h1104_1106);
    wb_end();
    repeat (2) @(negedge sdram_clk);
    check("miss_acc_cycles", 32'(acc_cnt - a0), 32'd1);
    check("miss_ack_count", 32'(ack_cnt - k0), 32'd1);

    // read hit in the buffered line
    a0 = acc_cnt;
    wb_start(32'h0000_0108, 1'b0, 4'hF, 32'h0);
    wb_wait_ack(lat, rd);
    check("hit_latency", 32'(lat), 32'd2);
    check("hit_data", rd, 32'h1108_110A);
    wb_end();
    check("hit_no_acc", 32'(acc_cnt - a0), 32'd0);

    // full-word write through a hit line
    a0 = acc_cnt;
    wb_start(32'h0000_0108, 1'b1, 4'hF, 32'hAABB_CCDD);
    serve_write(ca, cd, cs, cw);
    check("wr_hi_adr", ca, 32'h0000_0108);
    check("wr_hi_dat", 32'(cd), 32'h0000_AABB);
    check("wr_hi_sel", 32'(cs), 32'd3);
    check("wr_hi_we", 32'(cw), 32'd1);
    serve_write(ca, cd, cs, cw);
    check("wr_lo_adr", ca, 32'h0000_010A);
    check("wr_lo_dat", 32'(cd), 32'h0000_CCDD);
    check("wr_lo_sel", 32'(cs), 32'd3);
    wb_wait_ack(lat, rd);
    check("wr_acked", 32'(lat > 0), 32'd1);
    wb_end();
    check("wr_acc_cycles", 32'(acc_cnt - a0), 32'd2);
    a0 = acc_cnt;
    wb_start(32'h0000_0108, 1'b0, 4'hF, 32'h0);
    wb_wait_ack(lat, rd);
    check("reread_latency", 32'(lat), 32'd2);
    check("reread_data", rd, 32'hAABB_CCDD);
    wb_end();
    check("reread_no_acc", 32'(acc_cnt - a0), 32'd0);

    // byte-masked write-through: upper byte of the high halfword, lower byte of the low one
    wb_start(32'h0000_010C, 1'b1, 4'b1001, 32'h5566_7788);
    serve_write(ca, cd, cs, cw);
    check("mask_hi_adr", ca, 32'h0000_010C);
    check("mask_hi_sel", 32'(cs), 32'd2);
    serve_write(ca, cd, cs, cw);
    check("mask_lo_adr", ca, 32'h0000_010E);
    check("mask_lo_dat", 32'(cd), 32'h0000_7788);
    check("mask_lo_sel", 32'(cs), 32'd1);
    wb_wait_ack(lat, rd);
    wb_end();
    wb_start(32'h0000_010C, 1'b0, 4'hF, 32'h0);
    wb_wait_ack(lat, rd);
    check("mask_read", rd, 32'h550C_1188);
    wb_end();

    // low-half-only write and an empty-select write
    a0 = acc_cnt;
    wb_start(32'h0000_0200, 1'b1, 4'b0011, 32'h1234_5678);
    serve_write(ca, cd, cs, cw);
    check("lo_only_adr", ca, 32'h0000_0202);
    check("lo_only_dat", 32'(cd), 32'h0000_5678);
    check("lo_only_sel", 32'(cs), 32'd3);
    wb_wait_ack(lat, rd);
    check("lo_only_acked", 32'(lat > 0), 32'd1);
    wb_end();
    repeat (2) @(negedge sdram_clk);
    check("lo_only_acc_cycles", 32'(acc_cnt - a0), 32'd1);
    a0 = acc_cnt;
    wb_start(32'h0000_0204, 1'b1, 4'b0000, 32'hFFFF_FFFF);
    wb_wait_ack(lat, rd);
    check("sel0_acked", 32'(lat > 0), 32'd1);
    wb_end();
    check("sel0_no_acc", 32'(acc_cnt - a0), 32'd0);

    // cycle dropped during the fill: no ack, but the line is still stored
    k0 = ack_cnt;
    wb_start(32'h0000_0300, 1'b0, 4'hF, 32'h0);
    serve_read(32'h0000_0300, 2, ca, cw);
    repeat (6) @(negedge sdram_clk);
    check("drop_no_ack", 32'(ack_cnt - k0), 32'd0);
    a0 = acc_cnt;
    wb_start(32'h0000_0308, 1'b0, 4'hF, 32'h0);
    wb_wait_ack(lat, rd);
    check("drop_hit_latency", 32'(lat), 32'd2);
    check("drop_hit_data", rd, 32'h1308_130A);
    wb_end();
    check("drop_hit_no_acc", 32'(acc_cnt - a0), 32'd0);

    // reset while the low halfword is outstanding
    wb_start(32'h0000_030C, 1'b1, 4'hF, 32'hDEAD_BEEF);
    serve_write(ca, cd, cs, cw);
    check("rst_wr_hi_adr", ca, 32'h0000_030C);
    k0 = ack_cnt;
    sdram_rst = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge sdram_clk); #1;
    sdram_rst = 1'b0;
    @(negedge sdram_clk);
    check("mid_rst_acc", 32'(ctrl_acc_o), 32'd0);
    check("mid_rst_we", 32'(ctrl_we_o), 32'd0);
    check("mid_rst_adr", ctrl_adr_o, 32'd0);
    check("mid_rst_dat", 32'(ctrl_dat_o), 32'd0);
    check("mid_rst_sel", 32'(ctrl_sel_o), 32'd0);
    check("mid_rst_wb_dat", wb_dat_o, 32'd0);
    repeat (4) @(negedge sdram_clk);
    check("mid_rst_no_ack", 32'(ack_cnt - k0), 32'd0);
    a0 = acc_cnt;
    wb_start(32'h0000_0308, 1'b0, 4'hF, 32'h0);
    serve_read(32'h0000_0308, -1, ca, cw);
    check("post_rst_miss_adr", ca, 32'h0000_0308);
    wb_wait_ack(lat, rd);
    check("post_rst_data", rd, 32'h1308_130A);
    wb_end();
    check("post_rst_acc_cycles", 32'(acc_cnt - a0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
